// File: rtl/operand_pair_sync_pkg.sv
// Shared definitions for the operand pairing front end: stored token layout,
// control FSM encoding and default sizing.
package pkg_alu;

  localparam int DEF_WIDTH_DATA = 32;
  localparam int DEF_DEPTH      = 4;
  localparam int DEF_WAIT_LIMIT = 15;

  // One buffered operand token at the default data width.
  typedef struct packed {
    logic                      rls;
    logic [DEF_WIDTH_DATA-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/operand_pair_sync_token_fifo.sv
// token_fifo: small synchronous FIFO holding operand tokens. A push into a
// full FIFO and a pop from an empty FIFO are both ignored. Flush empties it.
module token_fifo
  import pkg_alu::*;
#(
  parameter int WIDTH = DEF_WIDTH_DATA + 1,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clock,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array carries no reset; only pointers and count define contents.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/operand_pair_sync.sv
// operand_pair_sync: buffers operand streams A and B, pairs their heads and
// presents one registered pair per cycle to the execution stage. A paired
// release token moves the block to DONE so downstream fires once per pair.
// Optional partner-wait timeout enabled by defining OPERAND_WAIT_TIMEOUT_EN;
// without it O_Timeout is tied low and no counter exists.
module operand_pair_sync
  import pkg_alu::*;
#(
  parameter int WIDTH_DATA = DEF_WIDTH_DATA,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int WAIT_LIMIT = DEF_WAIT_LIMIT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  I_Active,
  input  logic                  I_EnSrcA,
  input  logic                  I_EnSrcB,
  input  logic                  I_ValidA,
  input  logic                  I_RlsA,
  input  logic [WIDTH_DATA-1:0] I_DataA,
  input  logic                  I_ValidB,
  input  logic                  I_RlsB,
  input  logic [WIDTH_DATA-1:0] I_DataB,
  output logic                  O_NackA,
  output logic                  O_NackB,
  output logic                  O_Valid,
  output logic                  O_Rls,
  output logic [WIDTH_DATA-1:0] O_DataA,
  output logic [WIDTH_DATA-1:0] O_DataB,
  input  logic                  I_Nack,
  output logic                  O_Timeout
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = WIDTH_DATA + 1;

  // Same layout as pkg_alu::entry_t, at this instance's data width.
  typedef struct packed {
    logic                  rls;
    logic [WIDTH_DATA-1:0] data;
  } fifo_entry_t;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("operand_pair_sync: DEPTH must be a power of two, at least 2");
  end
  if (WAIT_LIMIT < 1 || WAIT_LIMIT > 255) begin : g_bad_wait_limit
    $error("operand_pair_sync: WAIT_LIMIT must be within 1..255");
  end

  state_t      state;
  logic        run;
  fifo_entry_t din_a, din_b;
  fifo_entry_t head_a, head_b;
  logic [CW-1:0] count_a, count_b;
  logic        full_a, full_b;
  logic        empty_a, empty_b;
  logic        push_a, push_b;
  logic        pop_a, pop_b;
  logic        head_ok_a, head_ok_b;
  logic        done_move;
  logic        flush;
  logic        pop_ok;
  logic        pair_rls;
  logic [WIDTH_DATA-1:0] pair_a, pair_b;

  assign run = (state == RUN);

  // Backpressure looks only at the registered count, so a full FIFO refuses
  // a push even in a cycle where it also pops.
  assign O_NackA = ~reset & ((count_a == CW'(DEPTH)) | ~run | ~I_Active);
  assign O_NackB = ~reset & ((count_b == CW'(DEPTH)) | ~run | ~I_Active);

  assign push_a = I_ValidA & I_EnSrcA & ~O_NackA & run & ~full_a;
  assign push_b = I_ValidB & I_EnSrcB & ~O_NackB & run & ~full_b;

  assign din_a = '{rls: I_RlsA, data: I_DataA};
  assign din_b = '{rls: I_RlsB, data: I_DataB};

  // A disabled stream never holds up pairing and contributes zeros.
  assign head_ok_a = ~empty_a | ~I_EnSrcA;
  assign head_ok_b = ~empty_b | ~I_EnSrcB;
  assign pair_a    = I_EnSrcA ? head_a.data : '0;
  assign pair_b    = I_EnSrcB ? head_b.data : '0;
  assign pair_rls  = (I_EnSrcA & head_a.rls) | (I_EnSrcB & head_b.rls);

  // Acceptance of the released pair ends the stream: leftovers are dropped
  // and no further pair is loaded behind it.
  assign done_move = run & O_Valid & O_Rls & ~I_Nack;
  assign flush     = reset | ~I_Active | done_move;

  assign pop_ok = run & head_ok_a & head_ok_b & (I_EnSrcA | I_EnSrcB) &
                  (~O_Valid | ~I_Nack) & ~done_move;
  assign pop_a  = pop_ok & I_EnSrcA;
  assign pop_b  = pop_ok & I_EnSrcB;

  token_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo_a (
    .clock (clock),
    .flush (flush),
    .push  (push_a),
    .pop   (pop_a),
    .din   (din_a),
    .dout  (head_a),
    .count (count_a),
    .full  (full_a),
    .empty (empty_a)
  );

  token_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo_b (
    .clock (clock),
    .flush (flush),
    .push  (push_b),
    .pop   (pop_b),
    .din   (din_b),
    .dout  (head_b),
    .count (count_b),
    .full  (full_b),
    .empty (empty_b)
  );

  // Control FSM: IDLE -> RUN on enable, RUN -> DONE on accepted release.
  always_ff @(posedge clock) begin
    if (reset || !I_Active) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    state <= RUN;
        RUN:     if (done_move) state <= DONE;
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output pair register: load on pop, hold under downstream nack.
  always_ff @(posedge clock) begin
    if (reset || !I_Active) begin
      O_Valid <= 1'b0;
      O_Rls   <= 1'b0;
      O_DataA <= '0;
      O_DataB <= '0;
    end else if (pop_ok) begin
      O_Valid <= 1'b1;
      O_Rls   <= pair_rls;
      O_DataA <= pair_a;
      O_DataB <= pair_b;
    end else if (!I_Nack) begin
      O_Valid <= 1'b0;
      O_Rls   <= 1'b0;
    end
  end

`ifdef OPERAND_WAIT_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       wait_cond;
  logic       timeout_q;

  // Waiting means both streams are in use but only one has a token queued.
  assign wait_cond = run & I_EnSrcA & I_EnSrcB & (empty_a ^ empty_b);

  // Count consecutive waiting cycles; flag sticks once the limit is reached.
  always_ff @(posedge clock) begin
    if (reset || !I_Active) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (wait_cond) begin
      if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
      if (({1'b0, wait_cnt} + 9'd1) == 9'(WAIT_LIMIT)) timeout_q <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  assign O_Timeout = timeout_q;
`else
  assign O_Timeout = 1'b0;
`endif

endmodule

// File: tb/tb_operand_pair_sync.sv
// Testbench for operand_pair_sync: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_operand_pair_sync;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int WL = 15;
`ifdef OPERAND_WAIT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         I_Active = 1'b0;
  logic         I_EnSrcA = 1'b0;
  logic         I_EnSrcB = 1'b0;
  logic         I_ValidA = 1'b0;
  logic         I_RlsA = 1'b0;
  logic [W-1:0] I_DataA = '0;
  logic         I_ValidB = 1'b0;
  logic         I_RlsB = 1'b0;
  logic [W-1:0] I_DataB = '0;
  logic         I_Nack = 1'b0;
  logic         O_NackA, O_NackB, O_Valid, O_Rls, O_Timeout;
  logic [W-1:0] O_DataA, O_DataB;

  always #5 clock = ~clock;

  operand_pair_sync #(.WIDTH_DATA(W), .DEPTH(D), .WAIT_LIMIT(WL)) dut (
    .clock     (clock),
    .reset     (reset),
    .I_Active  (I_Active),
    .I_EnSrcA  (I_EnSrcA),
    .I_EnSrcB  (I_EnSrcB),
    .I_ValidA  (I_ValidA),
    .I_RlsA    (I_RlsA),
    .I_DataA   (I_DataA),
    .I_ValidB  (I_ValidB),
    .I_RlsB    (I_RlsB),
    .I_DataB   (I_DataB),
    .O_NackA   (O_NackA),
    .O_NackB   (O_NackB),
    .O_Valid   (O_Valid),
    .O_Rls     (O_Rls),
    .O_DataA   (O_DataA),
    .O_DataB   (O_DataB),
    .I_Nack    (I_Nack),
    .O_Timeout (O_Timeout)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: queues of {rls,data}, a state number (0 idle, 1 run,
  // 2 done) and the output pair, advanced once per rising edge.
  logic [W:0]   qa[$];
  logic [W:0]   qb[$];
  int           mst = 0;
  bit           mv = 0, mrls = 0, mto = 0;
  logic [W-1:0] mda = '0, mdb = '0;
  int           mwc = 0;
  bit           model_on = 0;

  always @(posedge clock) begin : model
    bit nka, nkb, hoka, hokb, dm, pop, ne_a, ne_b;
    if (reset || !I_Active) begin
      qa.delete(); qb.delete();
      mst = 0; mv = 0; mrls = 0; mda = '0; mdb = '0; mto = 0; mwc = 0;
    end else begin
      ne_a = (qa.size() != 0);
      ne_b = (qb.size() != 0);
      nka  = (qa.size() == D) || (mst != 1);
      nkb  = (qb.size() == D) || (mst != 1);
      hoka = ne_a || !I_EnSrcA;
      hokb = ne_b || !I_EnSrcB;
      dm   = (mst == 1) && mv && mrls && !I_Nack;
      pop  = (mst == 1) && hoka && hokb && (I_EnSrcA || I_EnSrcB) && (!mv || !I_Nack) && !dm;
      if (TO_EN) begin
        if ((mst == 1) && I_EnSrcA && I_EnSrcB && (ne_a != ne_b)) begin
          if (mwc < 255) mwc = mwc + 1;
          if (mwc == WL) mto = 1;
        end else begin
          mwc = 0;
        end
      end
      if (pop) begin
        mv = 1; mrls = 0; mda = '0; mdb = '0;
        if (I_EnSrcA) begin mda = qa[0][W-1:0]; mrls = mrls | qa[0][W]; void'(qa.pop_front()); end
        if (I_EnSrcB) begin mdb = qb[0][W-1:0]; mrls = mrls | qb[0][W]; void'(qb.pop_front()); end
      end else if (!I_Nack) begin
        mv = 0; mrls = 0;
      end
      if (I_ValidA && I_EnSrcA && !nka) qa.push_back({I_RlsA, I_DataA});
      if (I_ValidB && I_EnSrcB && !nkb) qb.push_back({I_RlsB, I_DataB});
      if (dm) begin qa.delete(); qb.delete(); end
      if (mst == 0) mst = 1;
      else if (mst == 1 && dm) mst = 2;
    end
    model_on = 1;
  end

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clock) begin : compare
    bit ena, enb;
    if (model_on) begin
      ena = !reset && ((qa.size() == D) || (mst != 1) || !I_Active);
      enb = !reset && ((qb.size() == D) || (mst != 1) || !I_Active);
      chk("model_nack_a", O_NackA, ena);
      chk("model_nack_b", O_NackB, enb);
      chk("model_valid", O_Valid, mv);
      chk("model_rls", O_Rls, mrls);
      chk("model_timeout", O_Timeout, mto);
      if (mv) begin
        chk("model_data_a", O_DataA, mda);
        chk("model_data_b", O_DataB, mdb);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  int ka, kb;

  // Upstream that holds its token while nacked and advances once accepted.
  task automatic feed_cycle(input logic nk);
    bit acc_a, acc_b;
    I_Nack   = nk;
    I_ValidA = (ka <= 10);
    I_DataA  = 32'(ka);
    I_ValidB = (kb <= 10);
    I_DataB  = 32'(kb);
    I_RlsA   = 1'b0;
    I_RlsB   = 1'b0;
    acc_a = I_ValidA && !O_NackA;
    acc_b = I_ValidB && !O_NackB;
    step();
    if (acc_a) ka++;
    if (acc_b) kb++;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    // Reset and first pair
    repeat (3) step();
    chk("rst_valid", O_Valid, 0);
    chk("rst_rls", O_Rls, 0);
    chk("rst_nack_a", O_NackA, 0);
    chk("rst_nack_b", O_NackB, 0);
    chk("rst_data_a", O_DataA, 0);
    chk("rst_timeout", O_Timeout, 0);
    reset = 0; I_Active = 1; I_EnSrcA = 1; I_EnSrcB = 1;
    step();
    I_ValidA = 1; I_DataA = 5; I_ValidB = 1; I_DataB = 7;
    step();
    I_ValidA = 0; I_ValidB = 0;
    step();
    chk("first_valid", O_Valid, 1);
    chk("first_data_a", O_DataA, 5);
    chk("first_data_b", O_DataB, 7);
    chk("first_rls", O_Rls, 0);
    step();
    chk("first_clear", O_Valid, 0);

    // Skewed arrival
    I_ValidA = 1; I_DataA = 3;
    step();
    I_ValidA = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("skew_wait", O_Valid, 0);
    end
    I_ValidB = 1; I_DataB = 4;
    step();
    I_ValidB = 0;
    chk("skew_b_pushed", O_Valid, 0);
    step();
    chk("skew_valid", O_Valid, 1);
    chk("skew_data_a", O_DataA, 3);
    chk("skew_data_b", O_DataB, 4);
    step();
    chk("skew_clear", O_Valid, 0);

    // Downstream backpressure with both streams sending 1..10
    ka = 1; kb = 1;
    for (int i = 0; i < 10; i++) begin
      feed_cycle(1'b1);
      if (i == 3) chk("bp_nack_a_open", O_NackA, 0);
      if (i == 4) begin
        chk("bp_nack_a_full", O_NackA, 1);
        chk("bp_nack_b_full", O_NackB, 1);
      end
    end
    chk("bp_hold_valid", O_Valid, 1);
    chk("bp_hold_a", O_DataA, 1);
    chk("bp_hold_b", O_DataB, 1);
    for (int j = 0; j < 9; j++) begin
      feed_cycle(1'b0);
      chk("bp_drain_valid", O_Valid, 1);
      chk("bp_drain_a", O_DataA, 64'(j + 2));
      chk("bp_drain_b", O_DataB, 64'(j + 2));
    end
    I_ValidA = 0; I_ValidB = 0;
    step();
    chk("bp_end", O_Valid, 0);

    // Single operand stream
    I_EnSrcB = 0;
    I_ValidA = 1; I_DataA = 9;
    step();
    I_ValidA = 0;
    step();
    chk("single_valid", O_Valid, 1);
    chk("single_data_a", O_DataA, 9);
    chk("single_data_b", O_DataB, 0);
    chk("single_nack_b", O_NackB, 0);
    step();
    chk("single_clear", O_Valid, 0);
    I_EnSrcB = 1;

    // Release token and flush
    I_ValidA = 1; I_DataA = 1; I_RlsA = 0; I_ValidB = 1; I_DataB = 1;
    step();
    I_DataA = 2; I_RlsA = 1; I_DataB = 2;
    step();
    chk("rls_p1_valid", O_Valid, 1);
    chk("rls_p1_rls", O_Rls, 0);
    chk("rls_p1_a", O_DataA, 1);
    I_ValidA = 0; I_ValidB = 0; I_RlsA = 0;
    step();
    chk("rls_p2_valid", O_Valid, 1);
    chk("rls_p2_rls", O_Rls, 1);
    chk("rls_p2_a", O_DataA, 2);
    chk("rls_p2_b", O_DataB, 2);
    step();
    chk("done_valid", O_Valid, 0);
    chk("done_nack_a", O_NackA, 1);
    chk("done_nack_b", O_NackB, 1);
    I_Active = 0;
    step();
    chk("off_valid", O_Valid, 0);
    chk("off_rls", O_Rls, 0);
    chk("off_data_a", O_DataA, 0);
    chk("off_data_b", O_DataB, 0);
    chk("off_timeout", O_Timeout, 0);

    // Partner wait: A queued, B never arrives
    I_Active = 1;
    step();
    I_ValidA = 1; I_DataA = 1;
    step();
    I_ValidA = 0;
    for (int n = 1; n < WL; n++) begin
      step();
      chk("wait_no_timeout", O_Timeout, 0);
    end
    step();
    chk("wait_timeout_rise", O_Timeout, TO_EN);
    repeat (3) begin
      step();
      chk("wait_timeout_sticky", O_Timeout, TO_EN);
    end
    chk("wait_no_pair", O_Valid, 0);
    I_Active = 0;
    step();
    chk("wait_timeout_clear", O_Timeout, 0);

    reset = 1;
    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
